// File: rtl/jk_sequence_controller.sv
// jk_sequence_controller: command FSM (IDLE/EXEC/DONE) steering J/K drives into a bank of JK flip-flops.
module jk_sequence_controller #(
  parameter int WIDTH = 4,
  parameter int CNTW = 8
) (
  input  logic             clockPulse,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNTW-1:0]  cmd_count,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_Inverter,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2;
  localparam logic [2:0] OP_LOAD = 3'b001, OP_CLEAR = 3'b010, OP_TOGGLE = 3'b011,
                         OP_UP = 3'b100, OP_DOWN = 3'b101;
  logic [1:0] state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d, q_q, q_d, up, dn, cnt_jk;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic blk_q, blk_d, accept, exec, is_cnt, step;

  function automatic logic [WIDTH-1:0] low_mask(input int n);
    return (WIDTH'(1) << n) - WIDTH'(1);
  endfunction

  // Counter toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    up = '0;
    dn = '0;
    for (int i = 0; i < WIDTH; i++) begin
      up[i] = &(q_q | ~low_mask(i));
      dn[i] = &(~q_q | ~low_mask(i));
    end
  end

  assign exec   = state_q == EXEC;
  assign is_cnt = op_q == OP_UP || op_q == OP_DOWN;
  assign step   = is_cnt && cnt_q != '0;
  assign cnt_jk = op_q == OP_DOWN ? dn : up;
  assign J = !exec ? '0 :
             (op_q == OP_LOAD || op_q == OP_TOGGLE) ? data_q :
             step ? cnt_jk : '0;
  assign K = !exec ? '0 :
             op_q == OP_LOAD ? ~data_q :
             op_q == OP_CLEAR ? '1 :
             op_q == OP_TOGGLE ? data_q :
             step ? cnt_jk : '0;

  // Blocks acceptance on the first edge after reset releases.
  assign cmd_ready  = state_q == IDLE && !blk_q && !reset;
  assign accept     = cmd_valid && cmd_ready;
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign err        = done && op_q[2:1] == 2'b11;
  assign Q          = q_q;
  assign Q_Inverter = ~q_q;

  always_comb begin
    q_d     = (J & ~q_q) | (~K & q_q);
    state_d = state_q == IDLE ? (accept ? EXEC : IDLE) :
              exec ? (is_cnt && cnt_q > CNTW'(1) ? EXEC : DONE) : IDLE;
    op_d    = accept ? cmd_op : op_q;
    data_d  = accept ? cmd_data : data_q;
    cnt_d   = accept ? cmd_count : (exec && cnt_q != '0) ? cnt_q - CNTW'(1) : cnt_q;
    blk_d   = 1'b0;
  end

  always_ff @(posedge clockPulse or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      blk_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      blk_q   <= blk_d;
    end
  end
endmodule
